// File: rtl/regfile_write_buffer.sv
// Purpose : register-file write side; queues write requests in an in-order FIFO and owns the array plus two read ports.
// Latency : a write accepted at edge N commits at edge N+1 at the earliest; reads are combinational.
// Backpr. : wr_ready = !full (no same-cycle refill); commit_en low holds the queue.
// Option  : define REGFILE_WB_BYPASS_EN to forward the youngest matching queued write onto op1/op2.
module regfile_write_buffer #(
    parameter int ADDR_W = 1,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [31:0]                wr_data,
    input  logic                       commit_en,
    input  logic [ADDR_W-1:0]          ra0,
    input  logic [ADDR_W-1:0]          ra1,
    output logic [31:0]                op1,
    output logic [31:0]                op2,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       empty,
    output logic                       full
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Register array and write queue
    logic [31:0]       regs_q      [NREGS];
    logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
    logic [31:0]       fifo_data_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [31:0]       head_data;

    // Architectural reset image of the register array
    function automatic logic [31:0] reset_val(input int r);
        logic [31:0] v;
        case (r)
            0:       v = 32'h0005_0045;
            1:       v = 32'h0005_1F15;
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

    // Read one port: array value, optionally overridden by the youngest queued write to the same address
    function automatic logic [31:0] read_port(input logic [ADDR_W-1:0] ra);
        logic [31:0] rd;
        rd = regs_q[ra];
`ifdef REGFILE_WB_BYPASS_EN
        begin
            logic [PTR_W-1:0] idx;
            // Walk oldest to youngest so the last match wins
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr_q + PTR_W'(i);
                if ((CNT_W'(i) < cnt_q) && (fifo_addr_q[idx] == ra)) begin
                    rd = fifo_data_q[idx];
                end
            end
        end
`endif
        return rd;
    endfunction

    // Status decodes straight from the registered count
    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign wr_ready  = !full;
    assign pending   = cnt_q;

    // Handshake qualifiers; pop looks only at current occupancy, so a fresh push is never passed through
    assign push      = wr_valid && wr_ready;
    assign pop       = commit_en && !empty;
    assign head_addr = fifo_addr_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    // Next-state for pointers and occupancy count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Queue control state and register array, both cleared by reset (queued entries are discarded)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= reset_val(r);
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (pop) begin
                regs_q[head_addr] <= head_data;
            end
        end
    end

    // Queue payload storage; contents are qualified by the count, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr;
            fifo_data_q[wr_ptr_q] <= wr_data;
        end
    end

    // Combinational read ports
    always_comb begin
        op1 = read_port(ra0);
        op2 = read_port(ra1);
    end

endmodule

// File: tb/tb_regfile_write_buffer.sv
module tb_regfile_write_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [0:0]  wr_addr;
    logic [31:0] wr_data;
    logic        commit_en;
    logic [0:0]  ra0;
    logic [0:0]  ra1;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  pending;
    logic        empty;
    logic        full;

    int total = 0;
    int bad   = 0;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_write_buffer #(.ADDR_W(1), .DEPTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .commit_en(commit_en),
        .ra0      (ra0),
        .ra1      (ra1),
        .op1      (op1),
        .op2      (op2),
        .pending  (pending),
        .empty    (empty),
        .full     (full)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        commit_en = 1'b0;
        ra0       = 1'b0;
        ra1       = 1'b1;

        // Reset held two cycles
        step();
        step();
        rst_n = 1'b1;
        chk("rst_op1",      op1,               32'h0005_0045);
        chk("rst_op2",      op2,               32'h0005_1F15);
        chk("rst_empty",    {31'b0, empty},    32'd1);
        chk("rst_wr_ready", {31'b0, wr_ready}, 32'd1);
        chk("rst_full",     {31'b0, full},     32'd0);
        chk("rst_pending",  {30'b0, pending},  32'd0);

        // Single write with commit enabled: queued one cycle, then committed
        commit_en = 1'b1;
        wr_valid  = 1'b1;
        wr_addr   = 1'b1;
        wr_data   = 32'hDEAD_BEEF;
        step();
        wr_valid = 1'b0;
        chk("single_pending", {30'b0, pending}, 32'd1);
        chk("single_op2_q",   op2, BYP ? 32'hDEAD_BEEF : 32'h0005_1F15);
        step();
        chk("single_pending0", {30'b0, pending}, 32'd0);
        chk("single_empty",    {31'b0, empty},   32'd1);
        chk("single_op2",      op2,              32'hDEAD_BEEF);

        // Fill to full with commits held off
        commit_en = 1'b0;
        wr_valid  = 1'b1;
        wr_addr   = 1'b0;
        wr_data   = 32'h0000_0011;
        step();
        chk("fill_pending1", {30'b0, pending}, 32'd1);
        wr_data = 32'h0000_0022;
        step();
        chk("fill_pending2", {30'b0, pending}, 32'd2);
        chk("fill_full",     {31'b0, full},    32'd1);
        chk("fill_wr_ready", {31'b0, wr_ready}, 32'd0);
        // Third request held while full
        wr_addr = 1'b1;
        wr_data = 32'h0000_0033;
        step();
        chk("held_pending", {30'b0, pending}, 32'd2);
        chk("held_op1",     op1, BYP ? 32'h0000_0022 : 32'h0005_0045);
        chk("held_op2",     op2, BYP ? 32'hDEAD_BEEF : 32'hDEAD_BEEF);
        // Commit frees a slot but the full-cycle request is not taken
        commit_en = 1'b1;
        step();
        chk("drain_pending",  {30'b0, pending},  32'd1);
        chk("drain_wr_ready", {31'b0, wr_ready}, 32'd1);
        chk("drain_op1",      op1, BYP ? 32'h0000_0022 : 32'h0000_0011);
        // Push and commit together: count unchanged
        step();
        wr_valid = 1'b0;
        chk("pushpop_pending", {30'b0, pending}, 32'd1);
        chk("pushpop_op1",     op1, 32'h0000_0022);
        chk("pushpop_op2",     op2, BYP ? 32'h0000_0033 : 32'hDEAD_BEEF);
        step();
        chk("drain_empty", {31'b0, empty}, 32'd1);
        chk("drain_op2",   op2,            32'h0000_0033);

        // Ordering: two writes to reg0, last wins
        commit_en = 1'b0;
        wr_valid  = 1'b1;
        wr_addr   = 1'b0;
        wr_data   = 32'h0000_0001;
        step();
        wr_data = 32'h0000_0002;
        step();
        wr_valid = 1'b0;
        chk("ord_pending", {30'b0, pending}, 32'd2);
        chk("ord_op1_q",   op1, BYP ? 32'h0000_0002 : 32'h0000_0022);
        commit_en = 1'b1;
        step();
        chk("ord_op1_first", op1, BYP ? 32'h0000_0002 : 32'h0000_0001);
        step();
        chk("ord_op1_final", op1, 32'h0000_0002);
        chk("ord_empty",     {31'b0, empty}, 32'd1);

        // Forwarding visibility of a queued write
        commit_en = 1'b0;
        wr_valid  = 1'b1;
        wr_addr   = 1'b0;
        wr_data   = 32'h1234_5678;
        step();
        chk("byp_pending", {30'b0, pending}, 32'd1);
        chk("byp_op1",     op1, BYP ? 32'h1234_5678 : 32'h0000_0002);

        // Mid-operation reset with two entries queued
        wr_addr = 1'b1;
        wr_data = 32'hAAAA_5555;
        step();
        wr_valid = 1'b0;
        chk("mid_pending_pre", {30'b0, pending}, 32'd2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_pending", {30'b0, pending}, 32'd0);
        chk("mid_empty",   {31'b0, empty},   32'd1);
        chk("mid_op1",     op1,              32'h0005_0045);
        chk("mid_op2",     op2,              32'h0005_1F15);
        commit_en = 1'b1;
        step();
        step();
        chk("post_op1",     op1,              32'h0005_0045);
        chk("post_op2",     op2,              32'h0005_1F15);
        chk("post_pending", {30'b0, pending}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_buffer.md
# regfile_write_buffer

Write side of the 32-bit register file: accepts register write requests over a valid/ready handshake, queues them in a small in-order FIFO, and commits one entry per cycle into the register array when the datapath permits. It owns the register storage and exposes the two combinational read ports (`ra0`/`ra1` → `op1`/`op2`) that the operand-fetch logic consumes. Optional read-after-write forwarding from queued writes is compile-time selectable.

## Interface
- `ADDR_W`, 1: register address width; register count `NREGS = 2**ADDR_W`.
- `DEPTH`, 2: write FIFO entries; power of two, ≥ 2.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `wr_valid` input 1: write request present.
- `wr_ready` output 1: FIFO can accept; `= !full`.
- `wr_addr` input ADDR_W: destination register.
- `wr_data` input 32: write data.
- `commit_en` input 1: permits draining the FIFO head into the array this cycle.
- `ra0` input ADDR_W: read port 0 address.
- `ra1` input ADDR_W: read port 1 address.
- `op1` output 32: read data for `ra0` (combinational).
- `op2` output 32: read data for `ra1` (combinational).
- `pending` output clog2(DEPTH)+1: queued entry count.
- `empty` output 1: `pending == 0`.
- `full` output 1: `pending == DEPTH`.

## Operation
- Storage: `NREGS` × 32-bit registers. Reset values: reg0 = 32'h0005_0045, reg1 = 32'h0005_1F15, all others 32'h0.
- FIFO: circular buffer, read/write pointers wrap modulo `DEPTH`; count register distinguishes full from empty.
- Accept: `wr_valid && wr_ready` at an edge pushes {`wr_addr`, `wr_data`} at the tail.
- Commit: `commit_en && !empty` at an edge writes head data to `reg[head_addr]` and pops the head.
- Push and commit in the same cycle: both occur; `pending` unchanged; pointers each advance by one.
- Full: `wr_ready` low; `wr_valid` ignored, even if a commit frees a slot that same cycle (no same-cycle refill).
- Empty FIFO with push and `commit_en` high: the new entry is not committed that cycle (no pass-through).
- Multiple queued writes to one address commit in order; last one wins in the array.
- `commit_en` low: FIFO holds; array unchanged.
- Requester must hold `wr_addr`/`wr_data` stable while `wr_valid && !wr_ready`; `wr_valid` must not drop before acceptance.
- Reset: `pending` = 0, pointers = 0, `empty` = 1, `full` = 0, `wr_ready` = 1, array to reset values; queued entries discarded, including mid-burst.

## Timing
- `wr_ready`, `empty`, `full`, `pending`: registered-state decodes, valid the cycle after reset deasserts.
- Write accepted at edge N: earliest commit at edge N+1; array visible on `op1`/`op2` after that edge (no bypass).
- Read ports: zero latency, combinational from `ra*` and current state.
- Sustained throughput: one write/cycle with `commit_en` held high.

## Configuration
- `REGFILE_WB_BYPASS_EN` defined: `op1`/`op2` return the data of the youngest queued entry whose address matches `ra*`; if none, the array value. A write accepted at edge N is visible on reads from the cycle after edge N.
- Not defined: reads return array contents only; queued writes are invisible until committed.

## Test plan
- Reset: assert `rst_n` = 0 for 2 cycles → `op1` (ra0 = 0) = 32'h0005_0045, `op2` (ra1 = 1) = 32'h0005_1F15, `empty` = 1, `wr_ready` = 1.
- Single write: `commit_en` = 1, write reg1 ← 32'hDEAD_BEEF → `pending` = 1 for one cycle, then `op2` = 32'hDEAD_BEEF, `empty` = 1.
- Fill/full: `commit_en` = 0, push 2 writes (DEPTH = 2) → `full` = 1, `wr_ready` = 0; a third request is held without acceptance until `commit_en` = 1 drains one entry.
- Ordering: `commit_en` = 0, queue reg0 ← 1 then reg0 ← 2, release `commit_en` → `op1` shows 1 then 2; final 32'h2.
- Bypass (macro on): `commit_en` = 0, write reg0 ← 32'h1234_5678 → `op1` = 32'h1234_5678 next cycle while `pending` = 1. Macro off: `op1` stays 32'h0005_0045.
- Mid-operation reset: 2 queued entries, `rst_n` low 1 cycle → `pending` = 0, array back to reset values, nothing committed afterward.
